// File: rtl/shared_mem_responder_pkg.sv
// Shared types for the spcore shared-memory responder: FSM encoding, data width, RR helper.
// Latency: n/a (definitions only).  Backpressure: n/a.
package shared_mem_responder_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Round-robin successor of the granted core; wraps to core 0.
  function automatic int next_ptr(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/shared_mem_responder_if.sv
// Core request/response bus plus host preload port of the shared-memory responder.
// Latency: n/a (wiring only).  Backpressure: core_req held until core_ack; host holds host_we until host_ready.
interface shared_mem_responder_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 8
);

  logic [N_CORES-1:0]                                 core_req;
  logic [N_CORES-1:0]                                 core_we;
  logic [shared_mem_responder_pkg::DATA_W*N_CORES-1:0] core_addr;
  logic [shared_mem_responder_pkg::DATA_W*N_CORES-1:0] core_wdata;
  logic [shared_mem_responder_pkg::DATA_W*N_CORES-1:0] core_rdata;
  logic [N_CORES-1:0]                                 core_ack;
  logic                                               host_we;
  logic [ADDR_W-1:0]                                  host_addr;
  logic [shared_mem_responder_pkg::DATA_W-1:0]        host_wdata;
  logic                                               host_ready;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_we, host_addr, host_wdata,
    input  core_rdata, core_ack, host_ready
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_we, host_addr, host_wdata,
    output core_rdata, core_ack, host_ready
  );

endinterface

// File: rtl/shared_mem_responder_rr_arbiter.sv
// Round-robin picker: first requesting core at or above ptr, wrapping modulo N.
// Latency: combinational.  Backpressure: none, caller decides when to take the grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  int idx;

  // Scan farthest-from-ptr first so the nearest requester overwrites and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[IDX_W'(idx)]) begin
        grant               = '0;
        grant[IDX_W'(idx)]  = 1'b1;
        grant_idx           = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Shared single-port 16-bit RAM serving N_CORES spcore data ports, round-robin, with host preload.
// Latency: req seen in IDLE at t -> core_ack at t+2; one core access per 3 cycles.
// Backpressure: cores hold req until ack; host_ready low outside IDLE and host must hold host_we.
module shared_mem_responder
  import shared_mem_responder_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_mem_responder_if.slave bus
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    g_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q [N_CORES];
  logic [N_CORES-1:0]  ack_q;

  logic [N_CORES-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                any_req;
  logic                host_acc;
  logic                grant_now;

  rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_arb (
    .req       (bus.core_req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  // Host wins any IDLE cycle it strobes; cores wait for the next free IDLE.
  assign host_acc  = (state_q == ST_IDLE) && bus.host_we;
  assign grant_now = (state_q == ST_IDLE) && !bus.host_we && any_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_now) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      for (int i = 0; i < N_CORES; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (grant_now) begin
        g_q     <= arb_idx;
        we_q    <= bus.core_we[arb_idx];
        addr_q  <= bus.core_addr[int'(arb_idx)*DATA_W +: ADDR_W];
        wdata_q <= bus.core_wdata[int'(arb_idx)*DATA_W +: DATA_W];
      end
      // The read lands in the core's rdata register as the ack rises, so both appear in RESP.
      if (state_q == ST_ACCESS) begin
        ack_q[g_q] <= 1'b1;
        if (!we_q) rdata_q[g_q] <= mem[addr_q];
      end
      if (state_q == ST_RESP) ptr_q <= IDX_W'(next_ptr(int'(g_q), N_CORES));
    end
  end

  // RAM contents survive reset, but a write pending on the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (host_acc)
        mem[bus.host_addr] <= bus.host_wdata;
      else if (state_q == ST_ACCESS && we_q)
        mem[addr_q] <= wdata_q;
    end
  end

  assign bus.core_ack   = ack_q;
  assign bus.host_ready = (state_q == ST_IDLE);

  for (genvar i = 0; i < N_CORES; i++) begin : g_rdata
    assign bus.core_rdata[i*DATA_W +: DATA_W] = rdata_q[i];
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Scoreboard bench for shared_mem_responder: directed core/host traffic, expected acks queued at issue.
module tb_shared_mem_responder;

  localparam int N  = 4;
  localparam int AW = 8;

  typedef struct {
    int          core;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_mem_responder_if #(.N_CORES(N), .ADDR_W(AW)) bus ();

  shared_mem_responder #(.N_CORES(N), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   ack_cyc [N];
  int   ack_cnt [N];
  int   seen_cnt[N];
  int   rem     [N];
  int   t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  int   mc;
  exp_t me;
  initial begin
    for (int i = 0; i < N; i++) begin ack_cyc[i] = 0; ack_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      if (bus.core_ack != '0) begin
        mc = -1;
        for (int i = 0; i < N; i++) if (bus.core_ack[i]) mc = i;
        chk("ack_onehot", 32'($countones(bus.core_ack)), 32'd1);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: ack=%b, no access outstanding", bus.core_ack);
        end else begin
          me = sb.pop_front();
          chk("ack_core", 32'(mc), 32'(me.core));
          if (me.rd && mc >= 0) chk("rdata", 32'(bus.core_rdata[16*mc +: 16]), 32'(me.data));
        end
        if (mc >= 0) begin
          ack_cyc[mc] = cyc;
          ack_cnt[mc] = ack_cnt[mc] + 1;
        end
      end
    end
  end

  // Core side: drop req after the requested number of acks has been seen.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_cnt[i] != seen_cnt[i]) begin
        seen_cnt[i] = ack_cnt[i];
        if (rem[i] > 0) rem[i] = rem[i] - 1;
        if (rem[i] == 0) bus.core_req[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.core_req = '0;
    bus.host_we  = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [15:0] d);
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    tick();
    bus.host_we = 1'b0;
  endtask

  task automatic core_set(input int i, input logic we, input logic [15:0] a,
                          input logic [15:0] d, input int n);
    bus.core_we[i]             = we;
    bus.core_addr[16*i +: 16]  = a;
    bus.core_wdata[16*i +: 16] = d;
    rem[i]                     = n;
    bus.core_req[i]            = 1'b1;
  endtask

  task automatic push(input int c, input bit rd, input logic [15:0] d);
    exp_t e;
    e.core = c;
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (sb.size() == 0 && bus.core_req == '0 && bus.host_ready) break;
      tick();
    end
    n_chk++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL drain_%s: %0d acks still outstanding after 300 cycles", name, sb.size());
      sb.delete();
      bus.core_req = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seen_cnt[i] = 0; end

    // Reset state
    tick();
    tick();
    chk("rst_host_ready", 32'(bus.host_ready), 32'd1);
    chk("rst_ack", 32'(bus.core_ack), 32'd0);
    chk("rst_rdata", bus.core_rdata[31:0] | bus.core_rdata[63:32], 32'd0);
    reset = 1'b0;

    // 1: host preload then core 0 read, latency and host_ready
    host_wr(8'd5, 16'hBEEF);
    core_set(0, 1'b0, 16'h0005, 16'h0, 1);
    push(0, 1, 16'hBEEF);
    t0 = cyc;
    tick();
    chk("t1_ready_access", 32'(bus.host_ready), 32'd0);
    tick();
    chk("t1_ready_resp", 32'(bus.host_ready), 32'd0);
    drain("t1");
    chk("t1_latency", 32'(ack_cyc[0] - t0), 32'd2);
    chk("t1_rdata0_hold", 32'(bus.core_rdata[15:0]), 32'hBEEF);

    // 2: all four cores read at once after reset
    do_reset();
    host_wr(8'd10, 16'h1111);
    host_wr(8'd11, 16'h2222);
    host_wr(8'd12, 16'h3333);
    host_wr(8'd13, 16'h4444);
    for (int i = 0; i < N; i++) core_set(i, 1'b0, 16'(10 + i), 16'h0, 1);
    push(0, 1, 16'h1111);
    push(1, 1, 16'h2222);
    push(2, 1, 16'h3333);
    push(3, 1, 16'h4444);
    drain("t2");
    for (int i = 1; i < N; i++) chk("t2_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    chk("t2_rdata3", 32'(bus.core_rdata[63:48]), 32'h4444);

    // 3: aliased write by core 2, read back by core 1
    core_set(2, 1'b1, 16'h0107, 16'h1234, 1);
    push(2, 0, 16'h0);
    drain("t3w");
    core_set(1, 1'b0, 16'h0007, 16'h0, 1);
    push(1, 1, 16'h1234);
    drain("t3r");
    chk("t3_rdata1", 32'(bus.core_rdata[31:16]), 32'h1234);
    chk("t3_rdata2_kept", 32'(bus.core_rdata[47:32]), 32'h3333);

    // 4: host write and core 3 request in the same IDLE cycle
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'h20;
    bus.host_wdata = 16'h5A5A;
    core_set(3, 1'b0, 16'h0020, 16'h0, 1);
    push(3, 1, 16'h5A5A);
    t0 = cyc;
    tick();
    bus.host_we = 1'b0;
    drain("t4");
    chk("t4_latency", 32'(ack_cyc[3] - t0), 32'd3);

    // 5: reset while a core write sits in ACCESS
    host_wr(8'd9, 16'h0909);
    core_set(0, 1'b1, 16'h0009, 16'hAAAA, 1);
    tick();
    reset = 1'b1;
    bus.core_req = '0;
    rem[0] = 0;
    tick();
    chk("t5_ack", 32'(bus.core_ack), 32'd0);
    chk("t5_ready", 32'(bus.host_ready), 32'd1);
    chk("t5_rdata_lo", bus.core_rdata[31:0], 32'd0);
    chk("t5_rdata_hi", bus.core_rdata[63:32], 32'd0);
    tick();
    reset = 1'b0;
    core_set(1, 1'b0, 16'h0009, 16'h0, 1);
    push(1, 1, 16'h0909);
    drain("t5");

    // 6: cores 1 and 3 contend repeatedly; grants must alternate
    do_reset();
    core_set(1, 1'b0, 16'h0005, 16'h0, 2);
    core_set(3, 1'b0, 16'h0020, 16'h0, 2);
    push(1, 1, 16'hBEEF);
    push(3, 1, 16'h5A5A);
    push(1, 1, 16'hBEEF);
    push(3, 1, 16'h5A5A);
    drain("t6");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
